// File: rtl/mic_delay_array.sv
// Multi-channel steering delay stage: per-channel circular sample buffers read at a
// per-direction delay from a host-written table. Optional feature macro: MIC_DELAY_MUTE_EN.
module mic_delay_array #(
    parameter int CHANNELS  = 16,
    parameter int DATA_W    = 19,
    parameter int MAX_DELAY = 32,
    parameter int NUM_STEER = 32,
    parameter int MUTE_LEN  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [CHANNELS*DATA_W-1:0]    in_data,
    input  logic                          steer_load,
    input  logic [$clog2(NUM_STEER)-1:0]  steer_sel,
    input  logic                          tbl_we,
    input  logic [$clog2(NUM_STEER)-1:0]  tbl_dir,
    input  logic [$clog2(CHANNELS)-1:0]   tbl_ch,
    input  logic [$clog2(MAX_DELAY):0]    tbl_wdata,
    output logic                          out_valid,
    output logic [CHANNELS*DATA_W-1:0]    out_data,
    output logic [$clog2(NUM_STEER)-1:0]  active_steer,
    output logic                          steer_pending
);

    localparam int SW = $clog2(NUM_STEER);
    localparam int AW = $clog2(MAX_DELAY);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   pend_reg, pend_next;
    logic [SW-1:0]   active_reg, active_next;
    logic            apply;
    logic [SW-1:0]   use_dir;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW:0]     fill_reg;
    logic            out_valid_reg;
    logic            mute_now;
    logic [AW-1:0]   wdata_clamped;
    logic [AW-1:0]   tbl_reg [NUM_STEER][CHANNELS];

    // Steering FSM: a load is applied on the first sample strictly after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pend_reg   <= '0;
            active_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pend_reg   <= pend_next;
            active_reg <= active_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pend_next   = pend_reg;
        active_next = active_reg;
        apply       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (steer_load) begin
                    pend_next  = steer_sel;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                // A load colliding with a sample defers the switch to the next sample.
                if (steer_load) begin
                    pend_next = steer_sel;
                end else if (in_valid) begin
                    active_next = pend_reg;
                    state_next  = IDLE;
                    apply       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The applied sample already uses the new table row.
    assign use_dir = apply ? pend_reg : active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (fill_reg != (AW+1)'(MAX_DELAY))
                    fill_reg <= fill_reg + 1'b1;
            end
        end
    end

    assign wdata_clamped = (tbl_wdata > (AW+1)'(MAX_DELAY-1)) ? AW'(MAX_DELAY-1)
                                                              : tbl_wdata[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_STEER; d++)
                for (int c = 0; c < CHANNELS; c++)
                    tbl_reg[d][c] <= '0;
        end else if (tbl_we) begin
            tbl_reg[tbl_dir][tbl_ch] <= wdata_clamped;
        end
    end

`ifdef MIC_DELAY_MUTE_EN
    localparam int MW = $clog2(MUTE_LEN+1);
    logic [MW-1:0] mute_cnt_reg;

    // Counter holds the mutes still owed after the current sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_cnt_reg <= '0;
        end else if (in_valid) begin
            if (apply)
                mute_cnt_reg <= MW'(MUTE_LEN-1);
            else if (mute_cnt_reg != '0)
                mute_cnt_reg <= mute_cnt_reg - 1'b1;
        end
    end

    assign mute_now = apply || (mute_cnt_reg != '0);
`else
    logic unused_mute_len;
    assign unused_mute_len = ^MUTE_LEN;
    assign mute_now        = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DATA_W-1:0] din;
            logic [DATA_W-1:0] dout_reg;
            logic [AW-1:0]     dly;
            logic [AW-1:0]     rd_addr;
            logic [DATA_W-1:0] sample_mem [MAX_DELAY];

            assign din     = in_data[gi*DATA_W +: DATA_W];
            assign dly     = tbl_reg[use_dir][gi];
            assign rd_addr = wr_ptr_reg - dly;

            always_ff @(posedge clk) begin
                if (in_valid)
                    sample_mem[wr_ptr_reg] <= din;
            end

            // Slots not yet written since reset are masked by the fill count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_reg <= '0;
                end else if (in_valid) begin
                    if (mute_now)
                        dout_reg <= '0;
                    else if (dly == '0)
                        dout_reg <= din;
                    else if (fill_reg < {1'b0, dly})
                        dout_reg <= '0;
                    else
                        dout_reg <= sample_mem[rd_addr];
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = dout_reg;
        end
    endgenerate

    assign out_valid     = out_valid_reg;
    assign active_steer  = active_reg;
    assign steer_pending = (state_reg == PENDING);

endmodule

// File: tb/tb_mic_delay_array.sv
// Directed bench for mic_delay_array: passthrough, delay, wrap, clamp, steering,
// optional mute and asynchronous reset, with hand-derived expectations.
module tb_mic_delay_array;

    localparam int CHANNELS  = 16;
    localparam int DATA_W    = 19;
    localparam int MAX_DELAY = 32;
    localparam int NUM_STEER = 32;
    localparam int MUTE_LEN  = 8;
    localparam int W         = CHANNELS*DATA_W;
    localparam int SW        = $clog2(NUM_STEER);
    localparam int CW        = $clog2(CHANNELS);
    localparam int TW        = $clog2(MAX_DELAY)+1;
`ifdef MIC_DELAY_MUTE_EN
    localparam bit MUTE_ON = 1'b1;
`else
    localparam bit MUTE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          steer_load;
    logic [SW-1:0] steer_sel;
    logic          tbl_we;
    logic [SW-1:0] tbl_dir;
    logic [CW-1:0] tbl_ch;
    logic [TW-1:0] tbl_wdata;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] active_steer;
    logic          steer_pending;

    int tests_run    = 0;
    int tests_failed = 0;
    int mute_left    = 0;

    mic_delay_array #(
        .CHANNELS(CHANNELS), .DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY),
        .NUM_STEER(NUM_STEER), .MUTE_LEN(MUTE_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .steer_load(steer_load), .steer_sel(steer_sel), .tbl_we(tbl_we),
        .tbl_dir(tbl_dir), .tbl_ch(tbl_ch), .tbl_wdata(tbl_wdata),
        .out_valid(out_valid), .out_data(out_data),
        .active_steer(active_steer), .steer_pending(steer_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    function automatic logic [DATA_W-1:0] ch_of(input logic [W-1:0] d, input int c);
        return d[c*DATA_W +: DATA_W];
    endfunction

    function automatic logic [W-1:0] all_ch(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < CHANNELS; c++) r[c*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    // Expected channel value after accounting for any mute window the bench is tracking.
    function automatic logic [DATA_W-1:0] mx(input int raw);
        return (mute_left > 0) ? '0 : DATA_W'(raw);
    endfunction

    task automatic mute_tick();
        if (mute_left > 0) mute_left--;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic sl, input logic [SW-1:0] ss);
        in_valid   = v;
        in_data    = d;
        steer_load = sl;
        steer_sel  = ss;
        @(negedge clk);
        in_valid   = 1'b0;
        steer_load = 1'b0;
    endtask

    task automatic tbl_write(input int dir, input int ch, input int val);
        tbl_we    = 1'b1;
        tbl_dir   = SW'(dir);
        tbl_ch    = CW'(ch);
        tbl_wdata = TW'(val);
        @(negedge clk);
        tbl_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mute_left = 0;
    endtask

    initial begin
        logic [W-1:0] seq;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; steer_load = 1'b0; steer_sel = '0;
        tbl_we = 1'b0; tbl_dir = '0; tbl_ch = '0; tbl_wdata = '0;
        for (int c = 0; c < CHANNELS; c++) seq[c*DATA_W +: DATA_W] = DATA_W'(c+1);
        repeat (3) @(negedge clk);
        check_val("reset out_valid", W'(out_valid), W'(0));
        check_val("reset out_data", out_data, '0);
        check_val("reset active_steer", W'(active_steer), W'(0));
        check_val("reset steer_pending", W'(steer_pending), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Passthrough with an all-zero table.
        cyc(1'b1, seq, 1'b0, '0);
        check_val("pass out_valid", W'(out_valid), W'(1));
        check_val("pass out_data", out_data, seq);
        cyc(1'b0, '0, 1'b0, '0);
        check_val("pass idle out_valid", W'(out_valid), W'(0));
        check_val("pass held out_data", out_data, seq);

        // Single-channel delay of 5 on channel 3.
        do_reset();
        tbl_write(0, 3, 5);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, all_ch(k), 1'b0, '0);
            check_val($sformatf("delay5 ch3 k=%0d", k), W'(ch_of(out_data, 3)), W'(k > 5 ? k-5 : 0));
            check_val($sformatf("delay5 ch0 k=%0d", k), W'(ch_of(out_data, 0)), W'(k));
        end

        // Wrap-around at delay 31; channel 1 gets 40, which must clamp to 31.
        do_reset();
        tbl_write(0, 0, 31);
        tbl_write(0, 1, 40);
        for (int n = 0; n < 100; n++) begin
            cyc(1'b1, all_ch(n+1), 1'b0, '0);
            check_val($sformatf("wrap ch0 n=%0d", n), W'(ch_of(out_data, 0)), W'(n >= 31 ? n-30 : 0));
            check_val($sformatf("clamp ch1 n=%0d", n), W'(ch_of(out_data, 1)), W'(n >= 31 ? n-30 : 0));
            if (n % 10 == 0)
                check_val($sformatf("wrap ch5 n=%0d", n), W'(ch_of(out_data, 5)), W'(n+1));
        end

        // Steering collision: load in the same cycle as a sample defers the switch.
        do_reset();
        tbl_write(1, 0, 4);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, all_ch(k), 1'b0, '0);
            check_val($sformatf("steer pre ch0 k=%0d", k), W'(ch_of(out_data, 0)), W'(mx(k)));
            mute_tick();
        end
        cyc(1'b1, all_ch(4), 1'b1, SW'(1));
        check_val("collide ch0 old dir", W'(ch_of(out_data, 0)), W'(mx(4)));
        check_val("collide pending", W'(steer_pending), W'(1));
        check_val("collide active", W'(active_steer), W'(0));
        mute_tick();
        cyc(1'b0, '0, 1'b0, '0);
        check_val("gap pending", W'(steer_pending), W'(1));
        cyc(1'b1, all_ch(5), 1'b0, '0);
        mute_left = MUTE_ON ? MUTE_LEN : 0;
        check_val("apply ch0 delay4", W'(ch_of(out_data, 0)), W'(mx(1)));
        check_val("apply ch1", W'(ch_of(out_data, 1)), W'(mx(5)));
        check_val("apply pending", W'(steer_pending), W'(0));
        check_val("apply active", W'(active_steer), W'(1));
        mute_tick();
        cyc(1'b1, all_ch(6), 1'b0, '0);
        check_val("delay4 ch0 k=6", W'(ch_of(out_data, 0)), W'(mx(2)));
        mute_tick();
        tbl_write(1, 0, 2);
        cyc(1'b1, all_ch(7), 1'b0, '0);
        check_val("live write d2 k=7", W'(ch_of(out_data, 0)), W'(mx(5)));
        mute_tick();
        tbl_we = 1'b1; tbl_dir = SW'(1); tbl_ch = CW'(0); tbl_wdata = TW'(1);
        cyc(1'b1, all_ch(8), 1'b0, '0);
        tbl_we = 1'b0;
        check_val("same-cycle write k=8", W'(ch_of(out_data, 0)), W'(mx(6)));
        mute_tick();
        for (int k = 9; k <= 13; k++) begin
            cyc(1'b1, all_ch(k), 1'b0, '0);
            check_val($sformatf("d1 ch0 k=%0d", k), W'(ch_of(out_data, 0)), W'(mx(k-1)));
            check_val($sformatf("d1 ch1 k=%0d", k), W'(ch_of(out_data, 1)), W'(mx(k)));
            mute_tick();
        end

        // Last request wins while pending.
        cyc(1'b0, '0, 1'b1, SW'(2));
        check_val("multi pending", W'(steer_pending), W'(1));
        cyc(1'b0, '0, 1'b1, SW'(3));
        cyc(1'b1, all_ch(14), 1'b0, '0);
        mute_left = MUTE_ON ? MUTE_LEN : 0;
        check_val("last wins active", W'(active_steer), W'(3));
        check_val("last wins ch0", W'(ch_of(out_data, 0)), W'(mx(14)));
        mute_tick();

        // Reset discards a pending steer.
        cyc(1'b0, '0, 1'b1, SW'(5));
        check_val("pre-reset pending", W'(steer_pending), W'(1));
        do_reset();
        check_val("post-reset pending", W'(steer_pending), W'(0));
        check_val("post-reset active", W'(active_steer), W'(0));

        // Mid-stream asynchronous reset with fill=20.
        tbl_write(0, 2, 5);
        tbl_write(0, 6, 7);
        for (int k = 1; k <= 20; k++) cyc(1'b1, all_ch(k), 1'b0, '0);
        check_val("mid ch2 k=20", W'(ch_of(out_data, 2)), W'(15));
        check_val("mid ch6 k=20", W'(ch_of(out_data, 6)), W'(13));
        #2 rst_n = 1'b0;
        #1;
        check_val("async reset out_data", out_data, '0);
        check_val("async reset out_valid", W'(out_valid), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tbl_write(0, 2, 5);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, all_ch(k), 1'b0, '0);
            check_val($sformatf("after reset ch2 k=%0d", k), W'(ch_of(out_data, 2)), W'(k > 5 ? k-5 : 0));
            check_val($sformatf("table cleared ch6 k=%0d", k), W'(ch_of(out_data, 6)), W'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mic_delay_array.md
# mic_delay_array

Parametrised multi-channel steering delay stage for the microphone beamformer. Each PCM channel passes through its own circular sample buffer, with a per-channel integer delay taken from a writable steering table. Steering direction changes are applied glitch-free on sample boundaries. Sits between the PCM decimators and the channel summer; it generalises the fixed 16×19-bit delay stage to any channel count, width and depth, and adds a host-programmable delay table.

## Interface
- CHANNELS, 16, number of microphone channels
- DATA_W, 19, PCM sample width (signed, two's complement)
- MAX_DELAY, 32, buffer depth in samples; power of two ≥ 2; legal delays 0..MAX_DELAY-1
- NUM_STEER, 32, number of steering directions in the table
- MUTE_LEN, 32, samples muted after a steering change (used only with the macro)

- clk  in  1  sample-domain clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe: a new sample on every channel
- in_data  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- steer_load  in  1  one-cycle request to switch to direction steer_sel
- steer_sel  in  $clog2(NUM_STEER)  requested direction index
- tbl_we  in  1  delay table write strobe
- tbl_dir  in  $clog2(NUM_STEER)  table write direction index
- tbl_ch  in  $clog2(CHANNELS)  table write channel index
- tbl_wdata  in  $clog2(MAX_DELAY)+1  delay value to write
- out_valid  out  1  one-cycle strobe: out_data updated
- out_data  out  CHANNELS*DATA_W  delayed samples, same packing as in_data
- active_steer  out  $clog2(NUM_STEER)  direction applied to the most recent sample
- steer_pending  out  1  a steer_load has been accepted but not yet applied

## Operation
- Storage: per channel, a MAX_DELAY-entry buffer; one shared write pointer wr_ptr that wraps modulo MAX_DELAY; a fill counter that saturates at MAX_DELAY.
- On in_valid: buffer[c][wr_ptr] <= in_data[c]; wr_ptr increments and wraps; fill increments until saturated.
- Read on the same in_valid: d = table[active][c]. If d == 0, output is in_data[c] (bypass). Otherwise output is buffer[c][(wr_ptr - d) mod MAX_DELAY]. The output is forced to 0 while fill < d, because that sample has not yet been written.
- Table: NUM_STEER×CHANNELS delay registers. A tbl_we write is stored on the same edge. If tbl_wdata > MAX_DELAY-1, the stored value is clamped to MAX_DELAY-1. A write to the active direction affects the first in_valid after the write cycle.
- Steering FSM, two states:
  - IDLE: on steer_load, latch steer_sel into pend and go to PENDING.
  - PENDING: on the next in_valid strictly after the load cycle, active <= pend, go to IDLE. The new table row applies to that same sample.
  - A steer_load in PENDING overwrites pend; last request wins.
  - If steer_load and in_valid fall in the same cycle, the sample uses the old direction and the change applies at the next in_valid.
- steer_pending = (state == PENDING).
- No arithmetic on sample values. Data is moved bit-exact.

## Timing
- Latency: out_valid is asserted exactly one cycle after in_valid, for one cycle; out_data is registered and held between strobes.
- Back-to-back in_valid on every cycle is supported at full rate.
- Reset (asynchronous, rst_n low), values held until the first in_valid after release:
  - out_data = 0, out_valid = 0
  - wr_ptr = 0, fill = 0
  - active_steer = 0, steer_pending = 0, FSM in IDLE
  - all table entries = 0
  - buffer contents are don't-care; they are masked by fill.
- Reset mid-stream: on the edge rst_n falls, all of the above apply and any pending steer is discarded; a table write in that cycle is lost.

## Configuration
- MIC_DELAY_MUTE_EN defined: when a steering change is applied, a mute counter loads MUTE_LEN. For that sample and the following MUTE_LEN-1 samples, out_data = 0 while out_valid still pulses. A further steer applied during mute reloads the counter.
- MIC_DELAY_MUTE_EN undefined: no mute counter; outputs switch directly to the new delays on the applied sample.

## Test plan
- Passthrough: CHANNELS=16, table all 0, in_data channel c = c+1 -> out_valid 1 cycle after each in_valid, out_data channel c = c+1.
- Single-channel delay: table[0][3]=5, ramp input 1,2,3,… on all channels -> channel 3 outputs 0,0,0,0,0,1,2,…; other channels output the ramp undelayed.
- Wrap-around: MAX_DELAY=32, delay 31, 100-sample ramp with in_valid every cycle -> out_n = in_{n-31} for n ≥ 31 across three pointer wraps.
- Steer collision: direction 1 sets ch0=4; steer_load to 1 in the same cycle as in_valid -> that sample uses direction 0, the next sample uses delay 4, steer_pending is high for exactly that gap.
- Clamp and mute: write tbl_wdata=40 with MAX_DELAY=32 -> delay behaves as 31. With MIC_DELAY_MUTE_EN and MUTE_LEN=8, a steer change gives exactly 8 zero outputs.
- Reset mid-stream: assert rst_n low between in_valid strobes with fill=20 -> out_data=0 immediately. After release, a delay-5 channel outputs 0 for its first 5 samples.
